// File: rtl/bg_pkg.sv
// Shared definitions for the background scene sequencer: FSM state encoding,
// register map addresses and platform constants.
package bg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FADE_OUT = 2'd1,
    ST_SWITCH   = 2'd2,
    ST_FADE_IN  = 2'd3
  } bg_state_t;

  localparam logic [1:0] ADDR_REQ_BG = 2'd0;
  localparam logic [1:0] ADDR_SPEED  = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int unsigned NUM_BG_MAX = 4;
  localparam int unsigned H_WRAP_XGA = 1024;

endpackage

// File: rtl/bg_frame_tick.sv
// Frame tick generator: one-cycle pulse on the cycle after a vsync rising edge.
// Ports: clk, rst (async active-high), vsync (in), frame_tick (out, registered).
module bg_frame_tick (
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  output logic frame_tick
);

  logic r_vsync_d;
  logic r_tick;

  // History resets high so a vsync already high at reset release is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vsync_d <= 1'b1;
      r_tick    <= 1'b0;
    end else begin
      r_vsync_d <= vsync;
      r_tick    <= vsync & ~r_vsync_d;
    end
  end

  assign frame_tick = r_tick;

endmodule

// File: rtl/bg_scene_sequencer.sv
// Background scene sequencer: fades out, swaps the active background, fades
// back in; also drives horizontal scroll and star twinkle phase per frame.
// Optional feature macro BG_AUTO_CYCLE_EN: automatic background advance after
// AUTO_PERIOD idle frames when ctrl.auto_en is set.
// Ports:
//   clk, rst (async active-high), vsync (frame sync)
//   cfg_we/cfg_addr/cfg_wdata : register write port; cfg_rdata : comb readback
//   bg_sel, bg_en (one-hot), scroll_x, twinkle, fade_level, busy : registered
module bg_scene_sequencer
  import bg_pkg::*;
#(
  parameter int unsigned NUM_BG      = 4,
  parameter int unsigned FADE_FRAMES = 4,
  parameter int unsigned AUTO_PERIOD = 600,
  parameter int unsigned H_WRAP      = H_WRAP_XGA
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vsync,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [7:0]        cfg_wdata,
  output logic [7:0]        cfg_rdata,
  output logic [1:0]        bg_sel,
  output logic [NUM_BG-1:0] bg_en,
  output logic [9:0]        scroll_x,
  output logic [2:0]        twinkle,
  output logic [1:0]        fade_level,
  output logic              busy
);

  localparam logic [3:0] FADE_LAST = 4'(FADE_FRAMES - 1);

  bg_state_t         r_state;
  logic [1:0]        r_bg_sel;
  logic [NUM_BG-1:0] r_bg_en;
  logic [1:0]        r_req_bg;
  logic [3:0]        r_speed;
  logic [1:0]        r_ctrl;
  logic [9:0]        r_scroll;
  logic [2:0]        r_twinkle;
  logic [1:0]        r_fade;
  logic [3:0]        r_fade_cnt;
  logic              r_busy;

  logic              w_frame_tick;
  logic [10:0]       w_scroll_sum;
  logic [9:0]        w_scroll_next;
  logic [1:0]        w_req_mod;
  logic              w_req_wr;

  bg_frame_tick u_frame_tick (
    .clk        (clk),
    .rst        (rst),
    .vsync      (vsync),
    .frame_tick (w_frame_tick)
  );

  // Exact modular wrap: speed never exceeds 15, so one subtraction suffices.
  assign w_scroll_sum  = 11'(r_scroll) + 11'(r_speed);
  assign w_scroll_next = (w_scroll_sum >= 11'(H_WRAP)) ? 10'(w_scroll_sum - 11'(H_WRAP))
                                                       : 10'(w_scroll_sum);
  assign w_req_mod     = 2'(cfg_wdata % 8'(NUM_BG));
  assign w_req_wr      = cfg_we && (cfg_addr == ADDR_REQ_BG);

`ifdef BG_AUTO_CYCLE_EN
  localparam logic [9:0] AUTO_LAST = 10'(AUTO_PERIOD - 1);
  logic [9:0] r_auto_cnt;
  logic [1:0] w_auto_next;
  assign w_auto_next = 2'((32'(r_bg_sel) + 32'd1) % NUM_BG);
`else
  logic w_unused_auto;
  assign w_unused_auto = ^10'(AUTO_PERIOD);
`endif

  // Sequencer FSM plus frame-rate state and register file. Register writes are
  // placed last so a coincident frame tick sees pre-write values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_bg_sel   <= 2'd0;
      r_bg_en    <= NUM_BG'(1);
      r_req_bg   <= 2'd0;
      r_speed    <= 4'd1;
      r_ctrl     <= 2'b01;
      r_scroll   <= 10'd0;
      r_twinkle  <= 3'd0;
      r_fade     <= 2'd3;
      r_fade_cnt <= 4'd0;
      r_busy     <= 1'b0;
`ifdef BG_AUTO_CYCLE_EN
      r_auto_cnt <= 10'd0;
`endif
    end else begin
      if (w_frame_tick) begin
        r_twinkle <= r_twinkle + 3'd1;
        if (r_ctrl[0]) r_scroll <= w_scroll_next;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_frame_tick && (r_req_bg != r_bg_sel)) begin
            r_state    <= ST_FADE_OUT;
            r_busy     <= 1'b1;
            r_fade_cnt <= 4'd0;
          end
        end
        ST_FADE_OUT: begin
          if (w_frame_tick) begin
            if (r_fade_cnt == FADE_LAST) begin
              r_fade_cnt <= 4'd0;
              r_fade     <= r_fade - 2'd1;
              if (r_fade == 2'd1) r_state <= ST_SWITCH;
            end else begin
              r_fade_cnt <= r_fade_cnt + 4'd1;
            end
          end
        end
        ST_SWITCH: begin
          // Request sampled here; an unchanged request leaves the scene alone.
          if (r_req_bg != r_bg_sel) begin
            r_bg_sel <= r_req_bg;
            r_bg_en  <= NUM_BG'(1) << r_req_bg;
            r_scroll <= 10'd0;
          end
          r_state <= ST_FADE_IN;
        end
        ST_FADE_IN: begin
          if (w_frame_tick) begin
            if (r_fade_cnt == FADE_LAST) begin
              r_fade_cnt <= 4'd0;
              r_fade     <= r_fade + 2'd1;
              if (r_fade == 2'd2) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_fade_cnt <= r_fade_cnt + 4'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase

`ifdef BG_AUTO_CYCLE_EN
      // Idle frame counter; a host write of req_bg takes precedence.
      if (w_req_wr) begin
        r_auto_cnt <= 10'd0;
      end else if ((r_state == ST_IDLE) && w_frame_tick) begin
        if (r_req_bg != r_bg_sel) begin
          r_auto_cnt <= 10'd0;
        end else if (r_ctrl[1]) begin
          if (r_auto_cnt == AUTO_LAST) begin
            r_auto_cnt <= 10'd0;
            r_req_bg   <= w_auto_next;
          end else begin
            r_auto_cnt <= r_auto_cnt + 10'd1;
          end
        end
      end
`endif

      if (cfg_we) begin
        case (cfg_addr)
          ADDR_REQ_BG: r_req_bg <= w_req_mod;
          ADDR_SPEED:  r_speed  <= cfg_wdata[3:0];
`ifdef BG_AUTO_CYCLE_EN
          ADDR_CTRL:   r_ctrl   <= cfg_wdata[1:0];
`else
          ADDR_CTRL:   r_ctrl   <= {1'b0, cfg_wdata[0]};
`endif
          default: ;
        endcase
      end
    end
  end

  // Register readback.
  always_comb begin
    cfg_rdata = 8'h00;
    case (cfg_addr)
      ADDR_REQ_BG: cfg_rdata = {6'b0, r_req_bg};
      ADDR_SPEED:  cfg_rdata = {4'b0, r_speed};
      ADDR_CTRL:   cfg_rdata = {6'b0, r_ctrl};
      ADDR_STATUS: cfg_rdata = {r_busy, r_state, 3'b000, r_bg_sel};
      default:     cfg_rdata = 8'h00;
    endcase
  end

  assign bg_sel     = r_bg_sel;
  assign bg_en      = r_bg_en;
  assign scroll_x   = r_scroll;
  assign twinkle    = r_twinkle;
  assign fade_level = r_fade;
  assign busy       = r_busy;

endmodule

// File: doc/bg_scene_sequencer.md
BG_SCENE_SEQUENCER -- requirements
Module: bg_scene_sequencer

Interface
REQ-001 SHALL have parameter NUM_BG, default 4: number of selectable backgrounds (2..4).
REQ-002 SHALL have parameter FADE_FRAMES, default 4: frames per fade step (1..15).
REQ-003 SHALL have parameter AUTO_PERIOD, default 600: frames between automatic background advances (1..1023).
REQ-004 SHALL have parameter H_WRAP, default 1024: horizontal scroll modulus.
REQ-005 Port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-006 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 Port vsync, input, 1 bit: frame sync, synchronous to clk, active-high.
REQ-008 Port cfg_we, input, 1 bit: register write strobe, one cycle.
REQ-009 Port cfg_addr, input, 2 bits: register address.
REQ-010 Port cfg_wdata, input, 8 bits: write data.
REQ-011 Port cfg_rdata, output, 8 bits: read data for cfg_addr, combinational.
REQ-012 Port bg_sel, output, 2 bits: active background index.
REQ-013 Port bg_en, output, NUM_BG bits: one-hot of bg_sel.
REQ-014 Port scroll_x, output, 10 bits: horizontal scroll offset.
REQ-015 Port twinkle, output, 3 bits: star twinkle phase.
REQ-016 Port fade_level, output, 2 bits: brightness, 3 = full, 0 = black.
REQ-017 Port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-018 frame_tick SHALL pulse for one cycle on the cycle after a 0->1 transition of vsync.
REQ-019 Registers: addr0 req_bg[1:0]; addr1 speed[3:0]; addr2 ctrl {bit1 auto_en, bit0 scroll_en}; addr3 read-only status {busy, state[1:0], 3'b0, bg_sel}. Unused bits read 0, and writes to addr3 are ignored.
REQ-020 A req_bg write value >= NUM_BG SHALL be reduced modulo NUM_BG.
REQ-021 On frame_tick with scroll_en=1, scroll_x SHALL become (scroll_x + speed) mod H_WRAP. Wrap-around SHALL be exact, so 1020+6 gives 2.
REQ-022 twinkle SHALL increment modulo 8 on every frame_tick, regardless of state.
REQ-023 FSM states SHALL be IDLE, FADE_OUT, SWITCH and FADE_IN.
REQ-024 IDLE -> FADE_OUT SHALL occur on frame_tick when req_bg != bg_sel.
REQ-025 In FADE_OUT, fade_level SHALL decrement once every FADE_FRAMES frame_ticks. On the tick where it reaches 0, the FSM SHALL go to SWITCH.
REQ-026 SWITCH SHALL last exactly one clk cycle.
REQ-027 In SWITCH, if req_bg != bg_sel, the block SHALL set bg_sel <= req_bg and scroll_x <= 0. Otherwise both SHALL be left unchanged.
REQ-028 After SWITCH the FSM SHALL go to FADE_IN.
REQ-029 In FADE_IN, fade_level SHALL increment once every FADE_FRAMES frame_ticks. On reaching 3 the FSM SHALL go to IDLE.
REQ-030 A req_bg write while busy SHALL only update req_bg. It is sampled at SWITCH; a change after SWITCH is acted on from IDLE.
REQ-031 A cfg write and a frame_tick in the same cycle: the frame_tick logic SHALL use the pre-write register values.
REQ-032 When an entry into FADE_OUT and a scroll update coincide, both SHALL occur.
REQ-033 With FADE_FRAMES=1 and a request pending, the sequence from IDLE back to IDLE SHALL take 6 frame_ticks plus 1 cycle.

Reset
REQ-034 On rst: state=IDLE, bg_sel=0, req_bg=0, bg_en=1 (bit 0), scroll_x=0, twinkle=0, fade_level=3, busy=0, speed=1, ctrl=2'b01, all frame counters=0.
REQ-035 rst asserted mid-fade SHALL return the block to the REQ-034 values immediately.
REQ-036 After rst deasserts, the first frame_tick SHALL require a fresh vsync rising edge.

Configuration
REQ-037 Macro BG_AUTO_CYCLE_EN defined: in IDLE with auto_en=1, a frame counter counts frame_ticks.
REQ-038 When that counter reaches AUTO_PERIOD-1, req_bg SHALL become (bg_sel+1) mod NUM_BG and the counter SHALL clear.
REQ-039 The auto counter SHALL clear when leaving IDLE and on any req_bg write.
REQ-040 Macro BG_AUTO_CYCLE_EN undefined: no auto counter is built, ctrl bit1 SHALL read 0 and ignore writes, and all other behaviour is identical.

Structure
REQ-041 A shared package bg_pkg SHALL hold the FSM state encoding, register address constants, NUM_BG_MAX=4 and H_WRAP_XGA=1024.
REQ-042 A sub-module bg_frame_tick (vsync edge detector producing frame_tick) SHALL be instantiated.

Verification
REQ-043 Reset then 3 vsync pulses with speed=1, scroll_en=1 -> scroll_x=3, twinkle=3, fade_level=3, bg_en=4'b0001.
REQ-044 FADE_FRAMES=1, write req_bg=2, then vsync pulses -> fade_level 3,2,1,0, bg_sel=2 and scroll_x=0 in SWITCH, fade_level 1,2,3, then busy=0.
REQ-045 speed=6, scroll_x driven to 1020, one frame_tick -> scroll_x=2.
REQ-046 During FADE_OUT write req_bg=3, then req_bg=0 while bg_sel=0 -> SWITCH keeps bg_sel=0, FADE_IN still completes.
REQ-047 Assert rst at fade_level=1 in FADE_IN -> same cycle fade_level=3, busy=0, bg_sel=0.
REQ-048 BG_AUTO_CYCLE_EN defined, AUTO_PERIOD=5, auto_en=1 -> FADE_OUT starts on the 6th frame_tick, and bg_sel becomes 1.
